// File: rtl/next_pc_gen.sv
// Next-PC generator: selects the next fetch PC, tags delay slots and tracks unresolved branches in order.
// Optional static prediction of J/JAL and backward conditional branches is enabled by `STATIC_PREDICT_EN.
module next_pc_gen #(
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    BRANCH_ID_BIT   = 6,
    parameter int                    MAX_OUTSTANDING = 4,
    parameter logic [DATA_WIDTH-1:0] EXC_ENTRY       = 32'hBFC00380
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_WIDTH-1:0]    instr_i,
    input  logic [DATA_WIDTH-1:0]    pc_i,
    input  logic                     inst_valid_i,
    input  logic                     nextu_ready_i,
    output logic                     stall_o,
    input  logic                     br_valid_i,
    input  logic                     br_exception_i,
    input  logic                     br_taken_i,
    input  logic [DATA_WIDTH-1:0]    br_target_i,
    output logic                     br_ready_o,
    output logic                     redirect_o,
    output logic [DATA_WIDTH-1:0]    next_pc_o,
    output logic                     isdelayslot_o,
    output logic [BRANCH_ID_BIT-1:0] branch_id_o
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {S_NORM, S_DSLOT} state_t;

    typedef struct packed {
        logic                  pred;
        logic [DATA_WIDTH-1:0] pc8;
        logic [DATA_WIDTH-1:0] tgt;
    } entry_t;

    state_t                   state_q, state_d;
    logic [BRANCH_ID_BIT-1:0] id_q;
    logic [CW-1:0]            count_q;
    logic [CW-1:0]            wr_idx;
    entry_t                   q [MAX_OUTSTANDING];
    entry_t                   head, tail, new_entry;

    logic [5:0]               opcode, funct;
    logic [4:0]               rt;
    logic                     is_cond, is_jump, is_jreg, is_branch;
    logic                     new_pred;
    logic [DATA_WIDTH-1:0]    pc4, pc8, imm_ext, pred_tgt;
    logic                     fire, pop, push, mispredict, redirect;

    // MIPS32 branch/jump decode
    assign opcode = instr_i[31:26];
    assign rt     = instr_i[20:16];
    assign funct  = instr_i[5:0];

    always_comb begin
        is_cond = 1'b0;
        is_jump = 1'b0;
        is_jreg = 1'b0;
        case (opcode)
            6'b000100, 6'b000101, 6'b000110, 6'b000111: is_cond = 1'b1;
            6'b000001: is_cond = (rt == 5'b00000) | (rt == 5'b00001) |
                                 (rt == 5'b10000) | (rt == 5'b10001);
            6'b000010, 6'b000011: is_jump = 1'b1;
            6'b000000: is_jreg = (funct == 6'b001000) | (funct == 6'b001001);
            default: ;
        endcase
    end

    // A branch sitting in a delay slot is not a branch for tracking purposes
    assign is_branch = (state_q == S_NORM) & (is_cond | is_jump | is_jreg);

    assign pc4      = pc_i + DATA_WIDTH'(4);
    assign pc8      = pc_i + DATA_WIDTH'(8);
    assign imm_ext  = {{(DATA_WIDTH-18){instr_i[15]}}, instr_i[15:0], 2'b00};
    assign pred_tgt = is_jump ? {pc4[DATA_WIDTH-1:28], instr_i[25:0], 2'b00} : pc4 + imm_ext;

`ifdef STATIC_PREDICT_EN
    assign new_pred = is_jump | (is_cond & instr_i[15]);
`else
    assign new_pred = 1'b0;
`endif

    assign new_entry = '{pred: new_pred, pc8: pc8, tgt: pred_tgt};

    assign head = q[0];

    // The branch owning the current delay slot is the youngest queued entry
    always_comb begin
        tail = q[0];
        for (int i = 1; i < MAX_OUTSTANDING; i++) begin
            if (count_q == CW'(i + 1)) tail = q[i];
        end
    end

    // Resolution is held off while the oldest branch still owes its delay slot
    assign pop = br_valid_i & (count_q != '0) & ~((state_q == S_DSLOT) & (count_q == CW'(1)));

    assign mispredict = br_exception_i
                      | (br_taken_i & (~head.pred | (br_target_i != head.tgt)))
                      | (~br_taken_i & head.pred);
    assign redirect   = pop & mispredict;

    assign stall_o = is_branch & inst_valid_i & (count_q == CW'(MAX_OUTSTANDING)) & ~pop;
    assign fire    = inst_valid_i & nextu_ready_i & ~stall_o;
    assign push    = fire & is_branch & ~redirect;
    assign wr_idx  = pop ? count_q - CW'(1) : count_q;

    always_comb begin
        next_pc_o = pc4;
        if (redirect) begin
            if (br_exception_i)  next_pc_o = EXC_ENTRY;
            else if (br_taken_i) next_pc_o = br_target_i;
            else                 next_pc_o = head.pc8;
        end else if ((state_q == S_DSLOT) & fire & tail.pred) begin
            next_pc_o = tail.tgt;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_NORM:  if (push) state_d = S_DSLOT;
            S_DSLOT: if (fire) state_d = S_NORM;
        endcase
        if (redirect) state_d = S_NORM;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_NORM;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == S_DSLOT) & fire) id_q <= id_q + 1'b1;
        end
    end

    // Shift queue: entry 0 is always the oldest unresolved branch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) q[i] <= '0;
        end else if (redirect) begin
            count_q <= '0;
        end else begin
            if (pop) begin
                for (int i = 0; i < MAX_OUTSTANDING - 1; i++) q[i] <= q[i+1];
            end
            if (push) begin
                for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                    if (wr_idx == CW'(i)) q[i] <= new_entry;
                end
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    assign br_ready_o    = pop;
    assign redirect_o    = redirect;
    assign isdelayslot_o = (state_q == S_DSLOT);
    assign branch_id_o   = isdelayslot_o ? id_q : '0;

endmodule
